// File: rtl/conv_result_serializer.sv
// conv_result_serializer
// Captures a full convolution result window on a one-cycle valid pulse and
// streams it out one element per beat over a valid/ready interface. Two window
// slots form a ping-pong buffer so one window can drain while the next one is
// captured. The producer cannot be stalled, so a window that arrives while both
// slots are occupied is discarded and counted.
module conv_result_serializer #(
    parameter int QLEN        = 16,
    parameter int WINDOW_SIZE = 16,
    parameter int DROP_CNT_W  = 8,
    localparam int PTR_W      = $clog2(WINDOW_SIZE)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [WINDOW_SIZE-1:0][QLEN-1:0]    in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [QLEN-1:0]                     out_data,
    output logic [PTR_W-1:0]                    out_index,
    output logic                                out_last,
    output logic                                dropped,
    output logic [DROP_CNT_W-1:0]               drop_count
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(WINDOW_SIZE - 1);

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] val);
        if (val == {DROP_CNT_W{1'b1}})
            return val;
        return val + DROP_CNT_W'(1);
    endfunction

    state_t                             st;
    state_t                             st_nxt;
    logic [WINDOW_SIZE-1:0][QLEN-1:0]   slot [2];
    logic                               wr_slot;
    logic                               rd_slot;
    logic [1:0]                         occ;
    logic [1:0]                         occ_nxt;
    logic [PTR_W-1:0]                   idx;
    logic [PTR_W-1:0]                   idx_nxt;
    logic                               xfer;
    logic                               retire;
    logic                               accept;
    logic                               drop;

    // Handshake, retire/accept decisions and the resulting occupancy.
    // A window arriving with both slots full is still taken if the draining
    // window retires on the same edge, because that slot frees up exactly then.
    always_comb begin
        xfer    = out_valid && out_ready;
        retire  = xfer && (idx == LAST_IDX);
        accept  = in_valid && ((occ != 2'd2) || retire);
        drop    = in_valid && !accept;
        occ_nxt = occ;
        case ({accept, retire})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    // Next-state and output decode. Outputs depend only on registered state,
    // so nothing on the input side reaches an output combinationally.
    always_comb begin
        st_nxt    = st;
        idx_nxt   = idx;
        out_valid = 1'b0;
        case (st)
            ST_IDLE: begin
                if (occ_nxt != 2'd0)
                    st_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (xfer) begin
                    if (retire) begin
                        idx_nxt = '0;
                        // Another buffered window continues without a bubble.
                        if (occ_nxt == 2'd0)
                            st_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx + PTR_W'(1);
                    end
                end
            end
            default: begin
                st_nxt  = ST_IDLE;
                idx_nxt = '0;
            end
        endcase
    end

    // Beat outputs are a mux over the stored window and the element pointer.
    always_comb begin
        out_data  = slot[rd_slot][idx];
        out_index = idx;
        out_last  = out_valid && (idx == LAST_IDX);
    end

    // Control state: FSM, element pointer, slot pointers, occupancy, drop stats.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_IDLE;
            idx        <= '0;
            wr_slot    <= 1'b0;
            rd_slot    <= 1'b0;
            occ        <= 2'd0;
            dropped    <= 1'b0;
            drop_count <= '0;
        end else begin
            st      <= st_nxt;
            idx     <= idx_nxt;
            occ     <= occ_nxt;
            dropped <= drop;
            if (accept)
                wr_slot <= ~wr_slot;
            if (retire)
                rd_slot <= ~rd_slot;
            if (drop)
                drop_count <= sat_inc(drop_count);
        end
    end

    // Window storage. The write slot differs from the slot being drained
    // whenever a drain is in progress, except on the retire edge itself, when
    // the last beat leaves that slot on the same edge the new window lands.
    always_ff @(posedge clk) begin
        if (accept)
            slot[wr_slot] <= in_data;
    end

endmodule

// File: doc/conv_result_serializer.md
Name: conv_result_serializer

Overview:
- Consumer of the convolution engine's result window; the other end of its out_valid/out_data interface.
- Captures each WINDOW_SIZE-element result window on a one-cycle valid pulse and streams it out one QLEN-bit element per beat over a valid/ready interface.
- Two-slot ping-pong buffer: one window drains while the next is captured.
- The producer cannot be stalled, so windows that arrive when both slots are full are dropped and counted.

Parameters:
- QLEN, 16, element width in bits.
- WINDOW_SIZE, 16, elements per window; must be >= 2.
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  one-cycle pulse; in_data holds a complete result window.
- in_data  input  [WINDOW_SIZE-1:0][QLEN-1:0]  result window; element 0 is in_data[0].
- out_valid  output  1  out_data, out_index and out_last are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_data  output  QLEN  current element.
- out_index  output  PTR_W = $clog2(WINDOW_SIZE)  position of the current element in its window.
- out_last  output  1  high on the beat with out_index == WINDOW_SIZE-1.
- dropped  output  1  one-cycle pulse when an incoming window is discarded.
- drop_count  output  DROP_CNT_W  saturating count of discarded windows.

Behaviour:
- Reset values: out_valid=0, out_index=0, out_last=0, dropped=0, drop_count=0. Both slots are empty and the write and read slot pointers are 0. out_data is don't-care while out_valid=0.
- Storage: slot[0..1], each WINDOW_SIZE x QLEN. There is a 1-bit wr_slot, a 1-bit rd_slot and an occupancy counter occ in 0..2.
- Beat handshake: a beat transfers when out_valid && out_ready. out_data, out_index and out_last are held stable while out_valid && !out_ready. out_valid is never withdrawn without a transfer, except on reset.
- Window retire: a retire happens on a transfer with out_last=1. rd_slot toggles and occ decrements.
- Accept rule: an in_valid pulse is accepted if occ<2, or if occ==2 and a retire occurs in the same cycle.
- On accept: slot[wr_slot] <= in_data, wr_slot toggles and occ increments. If the same cycle also retires, occ is unchanged.
- On drop: slot contents are unchanged. dropped=1 on the next cycle, and drop_count increments, saturating at all-ones.
- FSM states:
  - ST_IDLE: out_valid=0. Go to ST_STREAM when occ becomes nonzero.
  - ST_STREAM: out_valid=1 and out_data = slot[rd_slot][out_index]. On each transfer, out_index increments.
  - On a retire in ST_STREAM: out_index returns to 0. If occ stays >0 after the retire, stay in ST_STREAM with no idle cycle (back-to-back windows). Otherwise go to ST_IDLE.
- Latency: a window accepted at edge N, with occ==0 before it, gives out_valid=1 and out_index=0 during cycle N+1. Sustained throughput with out_ready=1 is one element per cycle.
- All outputs are registered or taken from a mux of registers. There is no combinational path from in_valid or in_data to any output.
- A capture into slot[wr_slot] never corrupts slot[rd_slot] while that slot is being drained.
- Reset mid-stream: the partial window is abandoned, both slots are emptied, and no further beats from it appear.
- drop_count is not cleared by anything except rst.

Test Plan:
- Single window: in_data[i]=i+1 (QLEN=16), pulse, out_ready=1 -> beats 1..16 on cycles N+1..N+16, out_index 0..15, out_last only on the beat with value 16, then out_valid=0.
- Backpressure: same window, out_ready toggling 1,0,1,0... -> every value 1..16 appears exactly once, in order, and the outputs are held stable during each stall.
- Back-to-back: window A (values 0x100+i) accepted, then window B (0x200+i) pulsed 5 cycles later, out_ready=1 -> 32 contiguous beats, A then B, no gap; dropped never asserted.
- Overflow: out_ready=0, three pulses (A, B, C) -> occ=2, dropped pulses once, drop_count=1. Releasing out_ready then yields A followed by B; C never appears.
- Retire/accept collision: occ=2, in_valid pulse coincides with the last beat of the draining window -> window accepted, dropped=0, and the window streams after the remaining buffered one. Separately, 300 overflow pulses -> drop_count saturates at 255.
- Reset mid-stream: assert rst after beat 7 of a window -> out_valid=0 next cycle, drop_count=0, and a new window afterwards streams from out_index 0 with correct data.
